wb_arbiter: RTL

//  Writeback arbiter driving the single register-file write port (we/waddr/wdata).

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 84 ++++++++
 rtl/wb_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback arbiter
//
// Purpose: entry type stored in the long-latency result queue and the
//          register-zero constant. The entry field widths set the default
//          address/data widths of wb_arbiter and wb_fifo.
// Ports:   none (package)
package wb_pkg;

   localparam int WB_AW = 5;
   localparam int WB_DW = 32;

   localparam logic [WB_AW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic             live;
      logic [WB_AW-1:0] addr;
      logic [WB_DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - long-latency result queue with kill-by-address and pending mask
//
// Purpose: synchronous FIFO of wb_entry_t. Resident entries whose address
//          matches kill_addr while kill_en is high lose their live bit.
//          pend_mask flags every register targeted by a live resident entry.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   push, push_entry   write push_entry at the tail (caller guarantees not full)
//   pop                discard the head entry (caller guarantees not empty)
//   kill_en, kill_addr clear live on resident entries with this address
//   head               current head entry
//   empty              queue holds no entries
//   count              number of resident entries (live or dead)
//   pend_mask          one bit per register, set when a live entry targets it
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  wb_entry_t             push_entry,
   input  logic                  pop,
   input  logic                  kill_en,
   input  logic [WB_AW-1:0]      kill_addr,
   output wb_entry_t             head,
   output logic                  empty,
   output logic [PW:0]           count,
   output logic [(2**WB_AW)-1:0] pend_mask
);

   wb_entry_t   mem [DEPTH];
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;

   // Pointers carry one extra wrap bit, so their difference is the occupancy.
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign head  = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (mem[i].addr == kill_addr) begin
                  mem[i].live <= 1'b0;
               end
            end
         end
         // The tail slot is never resident when pushing, so this write
         // cannot collide with a kill of a live entry.
         if (push) begin
            mem[wr_ptr[PW-1:0]] <= push_entry;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Only slots between rd_ptr and wr_ptr count; stale slots keep old data.
   always_comb begin
      logic [PW-1:0] slot;
      pend_mask = '0;
      slot      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = rd_ptr[PW-1:0] + PW'(k);
         if (((PW+1)'(k) < count) && mem[slot].live) begin
            pend_mask[mem[slot].addr] = 1'b1;
         end
      end
      pend_mask[REG_ZERO] = 1'b0;
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter, pipeline over long-latency
//
// Purpose: owns the single register-file write port. Pipeline results always
//          win; long-latency results queue and drain in acceptance order on
//          cycles the pipeline leaves idle. A pipeline write kills queued
//          results for the same register so an older value never lands last.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   pipe_valid/pipe_waddr/pipe_wdata in-order WB result
//   md_valid/md_ready/md_waddr/md_wdata long-latency result handshake
//   rf_we/rf_waddr/rf_wdata          registered register-file write port
//   pend_mask                        live queued destinations, for hazard check
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = WB_AW,
   parameter int DW    = WB_DW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pipe_valid,
   input  logic [AW-1:0]      pipe_waddr,
   input  logic [DW-1:0]      pipe_wdata,
   input  logic               md_valid,
   output logic               md_ready,
   input  logic [AW-1:0]      md_waddr,
   input  logic [DW-1:0]      md_wdata,
   output logic               rf_we,
   output logic [AW-1:0]      rf_waddr,
   output logic [DW-1:0]      rf_wdata,
   output logic [(2**AW)-1:0] pend_mask
);

   localparam int PW = $clog2(DEPTH);

   wb_entry_t   head;
   wb_entry_t   push_entry;
   logic        empty;
   logic [PW:0] count;
   logic        pipe_sel;
   logic        md_accept;
   logic        push;
   logic        pop;

   assign pipe_sel  = pipe_valid && (pipe_waddr != REG_ZERO);
   assign md_ready  = (count < (PW+1)'(DEPTH));
   assign md_accept = md_valid && md_ready;

   // An md result arriving alongside a pipeline write to the same register is
   // older than that write, so it is acknowledged and thrown away.
   assign push = md_accept && (md_waddr != REG_ZERO) &&
                 !(pipe_sel && (md_waddr == pipe_waddr));
   assign pop  = !pipe_sel && !empty;

   assign push_entry = '{live: 1'b1, addr: md_waddr, data: md_wdata};

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .kill_en    (pipe_sel),
      .kill_addr  (pipe_waddr),
      .head       (head),
      .empty      (empty),
      .count      (count),
      .pend_mask  (pend_mask)
   );

   // Dead heads still pop, one per cycle, but leave the port idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (pipe_sel) begin
         rf_we    <= 1'b1;
         rf_waddr <= pipe_waddr;
         rf_wdata <= pipe_wdata;
      end else if (pop && head.live) begin
         rf_we    <= 1'b1;
         rf_waddr <= head.addr;
         rf_wdata <= head.data;
      end else begin
         rf_we    <= 1'b0;
      end
   end

endmodule
